video_window_crop: RTL
======================

Name: video_window_crop

Overview:
- Input-side stage that sits directly upstream of the frame buffer write path.
- Takes the raw camera/decoder pixel stream (vs/de/data, one clock) and passes only a configurable rectangular window.
- Produces the vs/de/vin stream the frame buffer consumes, so that only a window of the configured size is written per frame.
- Suppresses the partial frame after reset and reports per-frame geometry errors.

Parameters:
- VID_WIDTH, 16, pixel data width (matches the frame buffer I_VID_WIDTH).
- CNT_WIDTH, 11, width of pixel/line counters and geometry configuration (matches MAX_VID_WIDTH/MAX_VID_HIGHT).

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_vs  in  1  input vertical sync, active high.
- i_de  in  1  input data enable, active high.
- vin  in  VID_WIDTH  input pixel.
- x_start  in  CNT_WIDTH  first column kept, 0-based.
- y_start  in  CNT_WIDTH  first line kept, 0-based.
- win_w  in  CNT_WIDTH  window width in pixels.
- win_h  in  CNT_WIDTH  window height in lines.
- o_vs  out  1  i_vs delayed 1 clk.
- o_de  out  1  cropped data enable.
- vout  out  VID_WIDTH  cropped pixel; vin delayed 1 clk.
- frame_done  out  1  1-clk pulse at each frame boundary after the first.
- frame_err  out  1  1-clk pulse coincident with frame_done when the completed frame's window was short.
- last_lines  out  CNT_WIDTH  number of window lines emitted in the last completed frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_vs, o_de, frame_done, frame_err = 0; vout = 0; last_lines = 0.
  - All counters = 0; configuration shadow registers = 0; state = WAIT_VS.
  - Reset mid-frame behaves identically: the rest of that frame is dropped.
- Edge detect: registered i_vs_d and i_de_d.
  - vs_rise = i_vs & ~i_vs_d.
  - de_fall = ~i_de & i_de_d.
- State machine:
  - WAIT_VS: o_de forced 0. On vs_rise: latch x_start/y_start/win_w/win_h into shadow registers, clear x_cnt/y_cnt/line_out, go to ACTIVE. No frame_done is issued on this first vs_rise.
  - ACTIVE: on each vs_rise, first evaluate the completed frame, then relatch the configuration, clear the counters, and stay in ACTIVE.
    - Pulse frame_done.
    - last_lines <= line_out.
    - frame_err = 1 if line_out != win_h_shadow.
- Configuration is used only via the shadow registers; changes mid-frame take effect at the next vs_rise.
- x_cnt:
  - Increments on each i_de=1 cycle, saturating at 2^CNT_WIDTH-1.
  - Cleared on de_fall and on vs_rise.
  - The comparison uses the pre-increment value, i.e. the current pixel index.
- y_cnt:
  - Increments on de_fall, saturating at 2^CNT_WIDTH-1; cleared on vs_rise.
- in_win = (x_cnt >= xs) & (x_cnt < xs+ww) & (y_cnt >= ys) & (y_cnt < ys+wh), where xs/ys/ww/wh are the shadow values.
  - Sums are computed CNT_WIDTH+1 bits wide, so there is no wrap.
  - ww=0 or wh=0 gives no output pixels.
- Output register, latency exactly 1 clk for all stream signals:
  - o_de <= i_de & in_win & (state==ACTIVE).
  - vout <= vin whenever i_de=1; otherwise held.
  - o_vs <= i_vs.
- line_out:
  - Increments on de_fall when the line just ended had at least one in_win pixel.
  - Saturates at 2^CNT_WIDTH-1.
- Window larger than the source: output is truncated to the source; a short line count raises frame_err at the next boundary.
- Simultaneous vs_rise and de_fall: the de_fall's line_out increment is included before evaluation. The following counter clear wins over the increment.
- i_de asserted while i_vs=1: passed through normally (no blanking assumption).

Test Plan:
- rst=1 for 3 clks, then 8x4 frame (de 8 clks/line), window 0,0,8,4, first vs_rise mid-frame -> o_de stays 0 until the first vs_rise, then 32 o_de pulses at 1-clk latency with vout==vin delayed 1.
- 16x8 frames, x_start=4 y_start=2 win_w=6 win_h=3 -> per frame exactly 18 o_de cycles, on lines 2-4 at columns 4-9; next vs_rise gives frame_done=1, frame_err=0, last_lines=3.
- 16x8 frames, y_start=6 win_h=4 -> last_lines=2 and frame_err=1 pulse at the next vs_rise.
- win_w=0 -> no o_de for the whole frame; frame_err=1, last_lines=0.
- Change x_start from 0 to 8 mid-frame -> current frame keeps x_start=0; the change applies from the next frame.
- Assert rst for 1 clk in the middle of line 3 -> all outputs 0 the next clk; no o_de until the next vs_rise; no frame_done on that vs_rise.

Source files
------------

// File: rtl/video_window_crop.sv
// Crops a vs/de/data pixel stream to a configurable rectangular window ahead of
// the frame buffer write path, and reports per-frame window line counts.
module video_window_crop #(
  parameter int VID_WIDTH = 16,
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vs,
  input  logic                 i_de,
  input  logic [VID_WIDTH-1:0] vin,
  input  logic [CNT_WIDTH-1:0] x_start,
  input  logic [CNT_WIDTH-1:0] y_start,
  input  logic [CNT_WIDTH-1:0] win_w,
  input  logic [CNT_WIDTH-1:0] win_h,
  output logic                 o_vs,
  output logic                 o_de,
  output logic [VID_WIDTH-1:0] vout,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] last_lines
);

  typedef enum logic {WAIT_VS, ACTIVE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t               state_q, state_d;
  logic                 i_vs_d_q, i_de_d_q;
  logic [CNT_WIDTH-1:0] xs_q, ys_q, ww_q, wh_q;
  logic [CNT_WIDTH-1:0] xs_d, ys_d, ww_d, wh_d;
  logic [CNT_WIDTH-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [CNT_WIDTH-1:0] line_out_q, line_out_d, line_out_inc;
  logic                 line_hit_q, line_hit_d;
  logic [CNT_WIDTH-1:0] last_lines_q, last_lines_d;
  logic                 frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic                 o_vs_q, o_vs_d, o_de_q, o_de_d;
  logic [VID_WIDTH-1:0] vout_q, vout_d;

  logic                 vs_rise, de_fall, in_win;
  logic [CNT_WIDTH:0]   x_end, y_end;

  always_comb begin
    vs_rise = i_vs & ~i_vs_d_q;
    de_fall = ~i_de & i_de_d_q;
    // One extra bit so start+size never wraps back into range
    x_end   = {1'b0, xs_q} + {1'b0, ww_q};
    y_end   = {1'b0, ys_q} + {1'b0, wh_q};
    in_win  = (x_cnt_q >= xs_q) && ({1'b0, x_cnt_q} < x_end) &&
              (y_cnt_q >= ys_q) && ({1'b0, y_cnt_q} < y_end);
    line_out_inc = line_out_q;
    if (de_fall && line_hit_q && (line_out_q != CNT_MAX)) begin
      line_out_inc = line_out_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    xs_d         = xs_q;
    ys_d         = ys_q;
    ww_d         = ww_q;
    wh_d         = wh_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    line_hit_d   = line_hit_q;
    line_out_d   = line_out_inc;
    last_lines_d = last_lines_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (i_de) begin
      if (x_cnt_q != CNT_MAX) x_cnt_d = x_cnt_q + CNT_ONE;
      if (in_win) line_hit_d = 1'b1;
    end else if (de_fall) begin
      x_cnt_d    = '0;
      line_hit_d = 1'b0;
      if (y_cnt_q != CNT_MAX) y_cnt_d = y_cnt_q + CNT_ONE;
    end

    // Frame boundary: evaluate the finished frame (including a coincident
    // line end), then restart counting with freshly latched geometry.
    if (vs_rise) begin
      if (state_q == ACTIVE) begin
        frame_done_d = 1'b1;
        last_lines_d = line_out_inc;
        frame_err_d  = (line_out_inc != wh_q);
      end
      xs_d       = x_start;
      ys_d       = y_start;
      ww_d       = win_w;
      wh_d       = win_h;
      x_cnt_d    = '0;
      y_cnt_d    = '0;
      line_out_d = '0;
      line_hit_d = 1'b0;
      state_d    = ACTIVE;
    end

    o_de_d = i_de & in_win & (state_q == ACTIVE);
    vout_d = i_de ? vin : vout_q;
    o_vs_d = i_vs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_VS;
      i_vs_d_q     <= 1'b0;
      i_de_d_q     <= 1'b0;
      xs_q         <= '0;
      ys_q         <= '0;
      ww_q         <= '0;
      wh_q         <= '0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      line_out_q   <= '0;
      line_hit_q   <= 1'b0;
      last_lines_q <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      o_vs_q       <= 1'b0;
      o_de_q       <= 1'b0;
      vout_q       <= '0;
    end else begin
      state_q      <= state_d;
      i_vs_d_q     <= i_vs;
      i_de_d_q     <= i_de;
      xs_q         <= xs_d;
      ys_q         <= ys_d;
      ww_q         <= ww_d;
      wh_q         <= wh_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      line_out_q   <= line_out_d;
      line_hit_q   <= line_hit_d;
      last_lines_q <= last_lines_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      o_vs_q       <= o_vs_d;
      o_de_q       <= o_de_d;
      vout_q       <= vout_d;
    end
  end

  assign o_vs       = o_vs_q;
  assign o_de       = o_de_q;
  assign vout       = vout_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign last_lines = last_lines_q;

endmodule
